rob_mw: RTL
===========

ROB_MW -- requirements
Module: rob_mw

Interface
- REQ-001 SHALL have parameter ARCH, default 32, architectural register count.
- REQ-002 SHALL have parameter PHYS, default 64, physical register count.
- REQ-003 SHALL have parameter ROBN, default 16, entry count; power of two, ROBN >= 2*W.
- REQ-004 SHALL have parameter W, default 2, allocate/commit lanes.
- REQ-005 SHALL have parameter NWB, default 2, writeback ports.
- REQ-006 SHALL derive AW=$clog2(ARCH), PW=$clog2(PHYS), RW=$clog2(ROBN).
- REQ-007 SHALL have port clk, input, 1, the single clock; rising edge.
- REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-009 SHALL have port alloc_valid, input, W, per-lane allocate request; lanes contiguous from lane 0.
- REQ-010 SHALL have ports alloc_ard, alloc_prd_new and alloc_prd_old, inputs, W*AW, W*PW and W*PW, per-lane payload.
- REQ-011 SHALL have port alloc_ready, output, 1, high when free entries >= W.
- REQ-012 SHALL have port alloc_idx, output, W*RW, index assigned to each lane; lane k = tail+k mod ROBN.
- REQ-013 SHALL have ports wb_valid (NWB), wb_idx (NWB*RW), inputs, mark an entry ready by ROB index.
- REQ-014 SHALL have port commit_valid, output, W, per-lane retire-eligible; prefix-contiguous.
- REQ-015 SHALL have ports commit_ard, commit_prd_new and commit_prd_old, outputs, W*AW, W*PW and W*PW, payload at head+k.
- REQ-016 SHALL have port commit_ready, input, 1; retires every lane with commit_valid high.
- REQ-017 SHALL have port flush, input, 1, squashes all entries.
- REQ-018 SHALL have ports count (RW+1), empty and full, outputs, occupancy status.

Function
- REQ-019 SHALL accept allocation only when alloc_ready; lanes with alloc_valid high are written valid=1, rdy=0; tail advances by popcount(alloc_valid) mod ROBN.
- REQ-020 SHALL ignore alloc_valid while alloc_ready is low; non-contiguous alloc_valid is illegal (assertion).
- REQ-021 SHALL set rdy for each wb_valid port whose wb_idx entry is valid; writeback to an invalid entry is ignored; duplicate indices are legal.
- REQ-022 SHALL assert commit_valid[k] combinationally iff entries head..head+k are all valid and rdy, k < count.
- REQ-023 SHALL, when commit_ready is high, clear valid on retired entries and advance head by popcount(commit_valid) mod ROBN.
- REQ-024 SHALL make latency: alloc at cycle N is visible at N+1; wb at N sets commit_valid no earlier than N+1.
- REQ-025 SHALL update count by +alloc -commit on simultaneous alloc and commit; full = (count==ROBN); empty = (count==0).
- REQ-026 SHALL, on flush, clear all valid bits, set head=tail=0 and count=0 next cycle; flush overrides alloc, wb and commit that cycle.
- REQ-027 SHALL wrap head, tail and alloc_idx modulo ROBN with no bubble.

Reset
- REQ-028 SHALL on rst_n low asynchronously clear all entries, head, tail and count; outputs: alloc_ready=1, commit_valid=0, empty=1, full=0, count=0, alloc_idx lanes = 0..W-1.

Configuration
- REQ-029 SHALL, with ROB_EXC_EN defined, add input wb_exc (NWB), a per-entry exc bit set with rdy, and outputs exc_valid (1) and exc_idx (RW).
- REQ-030 SHALL, with ROB_EXC_EN, stop commit_valid before any entry with exc=1, assert exc_valid when the head entry is rdy with exc=1, and hold exc_idx=head until flush.
- REQ-031 SHALL, without ROB_EXC_EN, omit those ports and the exc bit, with commit governed by REQ-022 only.

Verification
- REQ-032 SHALL cover: reset, then 8 cycles of alloc_valid=2'b11 with commit_ready=0 -> full=1, alloc_ready=0 and count=16 after cycle 8; a 9th request is ignored.
- REQ-033 SHALL cover: alloc 4 entries, wb idx 1,0,3 -> commit_valid=2'b11; commit -> head=2 and commit_valid=2'b00 until idx 2 is written back.
- REQ-034 SHALL cover: head=15, tail=15, alloc two lanes -> alloc_idx={0,15}; both written back -> commit retires 15 then 0.
- REQ-035 SHALL cover: simultaneous alloc of 2 and commit of 1 at count=5 -> count=6.
- REQ-036 SHALL cover: flush asserted with count=7 and alloc_valid=2'b11 -> count=0, empty=1, head=tail=0, and no entries allocated.
- REQ-037 SHALL cover, with ROB_EXC_EN: head entry wb with wb_exc=1 -> commit_valid=0, exc_valid=1, exc_idx=head; flush -> exc_valid=0.

Source files
------------

// File: rtl/rob_mw.sv
// Multi-lane reorder buffer: W-wide in-order allocate and commit, NWB writeback ports.
// Optional exception tracking is compiled in when ROB_EXC_EN is defined.
module rob_mw #(
  parameter  int ARCH = 32,
  parameter  int PHYS = 64,
  parameter  int ROBN = 16,
  parameter  int W    = 2,
  parameter  int NWB  = 2,
  localparam int AW   = $clog2(ARCH),
  localparam int PW   = $clog2(PHYS),
  localparam int RW   = $clog2(ROBN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      alloc_valid,
  input  logic [W*AW-1:0]   alloc_ard,
  input  logic [W*PW-1:0]   alloc_prd_new,
  input  logic [W*PW-1:0]   alloc_prd_old,
  output logic              alloc_ready,
  output logic [W*RW-1:0]   alloc_idx,
  input  logic [NWB-1:0]    wb_valid,
  input  logic [NWB*RW-1:0] wb_idx,
`ifdef ROB_EXC_EN
  input  logic [NWB-1:0]    wb_exc,
  output logic              exc_valid,
  output logic [RW-1:0]     exc_idx,
`endif
  output logic [W-1:0]      commit_valid,
  output logic [W*AW-1:0]   commit_ard,
  output logic [W*PW-1:0]   commit_prd_new,
  output logic [W*PW-1:0]   commit_prd_old,
  input  logic              commit_ready,
  input  logic              flush,
  output logic [RW:0]       count,
  output logic              empty,
  output logic              full
);

  localparam logic [RW:0] ROBN_C = (RW+1)'(ROBN);
  localparam logic [RW:0] W_C    = (RW+1)'(W);

  logic [ROBN-1:0] valid_q, valid_d;
  logic [ROBN-1:0] rdy_q, rdy_d;
  logic [ROBN-1:0] exc_stop;
  logic [RW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [RW:0]     count_q, count_d;
  logic [RW:0]     n_alloc, n_commit;
  logic [RW-1:0]   aidx [W];
  logic [RW-1:0]   cidx [W];
  logic [AW-1:0]   ard_q    [ROBN];
  logic [PW-1:0]   prd_new_q[ROBN];
  logic [PW-1:0]   prd_old_q[ROBN];
  logic            alloc_contig;

`ifdef ROB_EXC_EN
  logic [ROBN-1:0] exc_q, exc_d;
  assign exc_stop  = exc_q;
  assign exc_valid = valid_q[head_q] & rdy_q[head_q] & exc_q[head_q];
  assign exc_idx   = head_q;
`else
  assign exc_stop  = '0;
`endif

  assign alloc_ready = (ROBN_C - count_q) >= W_C;
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == ROBN_C);

  for (genvar k = 0; k < W; k++) begin : g_lane
    assign aidx[k] = tail_q + RW'(k);
    assign cidx[k] = head_q + RW'(k);
    assign alloc_idx[k*RW +: RW]      = aidx[k];
    assign commit_ard[k*AW +: AW]     = ard_q[cidx[k]];
    assign commit_prd_new[k*PW +: PW] = prd_new_q[cidx[k]];
    assign commit_prd_old[k*PW +: PW] = prd_old_q[cidx[k]];
  end

  // A lane may retire only if every older lane in this group also retires.
  always_comb begin
    logic chain;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    chain        = 1'b1;
    commit_valid = '0;
    n_commit     = '0;
    for (int k = 0; k < W; k++) begin
      chain = chain && valid_q[cidx[k]] && rdy_q[cidx[k]] && !exc_stop[cidx[k]]
              && ((RW+1)'(k) < count_q);
      commit_valid[k] = chain;
      if (chain) n_commit = n_commit + (RW+1)'(1);
    end
  end

  always_comb begin
    n_alloc = '0;
    for (int k = 0; k < W; k++)
      if (alloc_valid[k]) n_alloc = n_alloc + (RW+1)'(1);
  end

  always_comb begin
    valid_d = valid_q;
    rdy_d   = rdy_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
`ifdef ROB_EXC_EN
    exc_d   = exc_q;
`endif
    for (int p = 0; p < NWB; p++) begin
      if (wb_valid[p] && valid_q[wb_idx[p*RW +: RW]]) begin
        rdy_d[wb_idx[p*RW +: RW]] = 1'b1;
`ifdef ROB_EXC_EN
        if (wb_exc[p]) exc_d[wb_idx[p*RW +: RW]] = 1'b1;
`endif
      end
    end
    if (commit_ready) begin
      for (int k = 0; k < W; k++)
        if (commit_valid[k]) valid_d[cidx[k]] = 1'b0;
      head_d  = head_q + RW'(n_commit);
      count_d = count_d - n_commit;
    end
    if (alloc_ready) begin
      for (int k = 0; k < W; k++) begin
        if (alloc_valid[k]) begin
          valid_d[aidx[k]] = 1'b1;
          rdy_d[aidx[k]]   = 1'b0;
`ifdef ROB_EXC_EN
          exc_d[aidx[k]]   = 1'b0;
`endif
        end
      end
      tail_d  = tail_q + RW'(n_alloc);
      count_d = count_d + n_alloc;
    end
    if (flush) begin
      valid_d = '0;
      rdy_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
`ifdef ROB_EXC_EN
      exc_d   = '0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rdy_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
`ifdef ROB_EXC_EN
      exc_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
`ifdef ROB_EXC_EN
      exc_q   <= exc_d;
`endif
    end
  end

  // NOTE: payload storage has no reset; it is only observed through entries whose valid bit is set.
  always_ff @(posedge clk) begin
    for (int k = 0; k < W; k++) begin
      if (alloc_ready && !flush && alloc_valid[k]) begin
        ard_q[aidx[k]]     <= alloc_ard[k*AW +: AW];
        prd_new_q[aidx[k]] <= alloc_prd_new[k*PW +: PW];
        prd_old_q[aidx[k]] <= alloc_prd_old[k*PW +: PW];
      end
    end
  end

  // Requesting lanes must form a run starting at lane 0.
  assign alloc_contig = ((alloc_valid & (alloc_valid + W'(1))) == '0);

  a_alloc_contig: assert property (@(posedge clk) disable iff (!rst_n) alloc_contig)
    else $error("rob_mw: non-contiguous alloc_valid %b", alloc_valid);

endmodule
